oam_dma_ctrl: RTL and testbench
===============================

Name: oam_dma_ctrl

Overview:
- Sprite DMA engine sitting on the CPU's external bus, directly downstream of the CPU's address/data/rw outputs and upstream of the memory/PPU bus.
- A CPU write of page number P to DMA_REG_ADDR halts the CPU via rdy.
- It then copies 256 bytes from $PP00-$PPFF to OAM_DATA_ADDR as alternating read/write bus cycles, and releases the bus.
- When idle it passes CPU bus signals through untouched.

Parameters:
- DMA_REG_ADDR, 16'h4014, CPU write address that triggers DMA.
- OAM_DATA_ADDR, 16'h2004, destination address written on every DMA put cycle.
- XFER_LEN, 256, bytes per transfer; the byte counter is 8 bits and wraps.

Ports:
- clk_ph1  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- cpu_addr  in  16  CPU address output.
- cpu_dout  in  8  CPU write data.
- cpu_rw  in  1  1 = CPU read cycle, 0 = CPU write cycle.
- bus_din  in  8  data returned by memory for the current bus address.
- rdy  out  1  CPU ready; 0 halts the CPU.
- bus_addr  out  16  address to memory/PPU.
- bus_dout  out  8  write data to memory/PPU.
- bus_rw  out  1  1 = read, 0 = write.
- dma_active  out  1  1 while the engine owns the bus.

Behaviour:
- Reset (rst=0, async): state=IDLE, rdy=1, dma_active=0, page=0, idx=0, latch=0, parity=0. Bus outputs pass through the CPU signals.
- parity: a free-running toggle flop, 0 after reset, flipping every clk_ph1 edge. parity=0 is a "get" cycle, parity=1 is a "put" cycle.
- IDLE: bus_addr=cpu_addr, bus_dout=cpu_dout, bus_rw=cpu_rw, rdy=1.
  - Trigger is cpu_addr==DMA_REG_ADDR with cpu_rw=0, sampled at an edge.
  - On trigger: page<=cpu_dout, idx<=0, go to HALT. rdy drops to 0 in the cycle after the trigger write.
- HALT: rdy=0, bus still passes through the CPU, because the CPU may finish write cycles.
  - Stay in HALT while cpu_rw=0.
  - On the first cycle with cpu_rw=1, the CPU is frozen and that read is the dummy (halt) cycle. Then:
    - if the next cycle is a get (current parity=1), go to READ;
    - otherwise go to ALIGN.
- ALIGN: one dummy cycle. dma_active=1, bus_addr=cpu_addr, bus_rw=1; go to READ.
- READ (always a get cycle): dma_active=1, bus_addr={page,idx}, bus_rw=1, latch<=bus_din; go to WRITE.
- WRITE (put cycle): bus_addr=OAM_DATA_ADDR, bus_dout=latch, bus_rw=0.
  - idx<=idx+1 (8-bit).
  - If idx==8'hFF, go to IDLE, with rdy=1 and dma_active=0 from the next cycle; otherwise go to READ.
- Latency from trigger edge to rdy=1:
  - 1 (HALT) + 0/1 (ALIGN) + 512 cycles when the CPU reads immediately, i.e. 513 or 514;
  - plus one cycle per extra CPU write cycle in HALT.
- Boundaries:
  - Source address never leaves page P. Page $FF reads $FF00-$FFFF; idx wrap does not carry into page.
  - Writes to DMA_REG_ADDR outside IDLE are ignored, because the CPU is halted and the bus is not from the CPU.
  - A write to any other address (e.g. $4015) never triggers.
  - Reads of DMA_REG_ADDR never trigger.
  - Reset mid-transfer aborts immediately to the reset state. No partial-transfer resume.
  - rdy is a registered output; it is never combinationally derived from cpu_addr.

Decomposition:
- Shared package nes_bus_pkg holds:
  - state encodings S_IDLE, S_HALT, S_ALIGN, S_READ, S_WRITE (3-bit);
  - the constants DMA_REG_ADDR and OAM_DATA_ADDR;
  - RW_READ=1 and RW_WRITE=0.
- No sub-module is needed. The bus mux is a single combinational always block inside oam_dma_ctrl.

Test Plan:
- Idle passthrough: cpu_addr=$0105, cpu_rw=1 -> bus_addr=$0105, bus_rw=1, rdy=1, dma_active=0. CPU write $0201<=$07 appears on bus_dout/bus_rw=0.
- Basic DMA: memory $0200+i = i^$5A. CPU writes $02 to $4014, then reads.
  - Required: rdy=0 the next cycle.
  - 256 writes to $2004 in order with data $5A,$5B,...
  - Reads at $0200..$02FF.
  - rdy=1 exactly 513 or 514 cycles after the trigger, matching parity; run both parities.
- HALT with pending writes: the CPU holds cpu_rw=0 for 2 cycles after the trigger -> first DMA read delayed by exactly 2 cycles; data is still correct.
- Page $FF wrap: trigger with $FF -> last read at $FFFF, no access to $0000; idx returns to 0.
- Non-triggers: write $4015 and read $4014 -> rdy stays 1 and dma_active stays 0 for 10 cycles.
- Reset mid-transfer: pull rst low at the 100th DMA write -> rdy=1 and dma_active=0 asynchronously. After release, the bus passes the CPU through and a new $4014 write runs a full 256-byte transfer.

Source files
------------

// File: rtl/nes_bus_pkg.sv
// Shared CPU-bus definitions for the sprite DMA engine.
package nes_bus_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_HALT  = 3'd1,
      S_ALIGN = 3'd2,
      S_READ  = 3'd3,
      S_WRITE = 3'd4
   } dma_state_t;

   localparam logic [15:0] DMA_REG_ADDR  = 16'h4014;
   localparam logic [15:0] OAM_DATA_ADDR = 16'h2004;
   localparam int          XFER_LEN      = 256;

   localparam logic RW_READ  = 1'b1;
   localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/oam_dma_ctrl.sv
// Sprite DMA: halts the CPU and copies page P to OAM as get/put bus cycle pairs.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | CPU owns the bus, watching for a write to DMA_REG_ADDR
//   S_HALT  | rdy low, CPU finishing write cycles; first read is dummy
//   S_ALIGN | extra dummy cycle so the first copy read lands on a get
//   S_READ  | get cycle: read {page,idx} into latch
//   S_WRITE | put cycle: write latch to OAM_DATA_ADDR, advance idx
module oam_dma_ctrl
   import nes_bus_pkg::*;
(
   input  logic        clk_ph1,
   input  logic        rst,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_dout,
   input  logic        cpu_rw,
   input  logic [7:0]  bus_din,
   output logic        rdy,
   output logic [15:0] bus_addr,
   output logic [7:0]  bus_dout,
   output logic        bus_rw,
   output logic        dma_active
);

   localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

   dma_state_t state;
   logic [7:0] page;
   logic [7:0] idx;
   logic [7:0] latch;
   logic       parity;

   always_ff @(posedge clk_ph1 or negedge rst) begin
      if (!rst) begin
         state      <= S_IDLE;
         rdy        <= 1'b1;
         dma_active <= 1'b0;
         page       <= 8'h00;
         idx        <= 8'h00;
         latch      <= 8'h00;
         parity     <= 1'b0;
      end else begin
         parity <= ~parity;
         case (state)
            S_IDLE: begin
               if (cpu_addr == DMA_REG_ADDR && cpu_rw == RW_WRITE) begin
                  page  <= cpu_dout;
                  idx   <= 8'h00;
                  rdy   <= 1'b0;
                  state <= S_HALT;
               end
            end
            S_HALT: begin
               // parity=1 now means the cycle after this dummy read is a get
               if (cpu_rw == RW_READ) begin
                  dma_active <= 1'b1;
                  state      <= parity ? S_READ : S_ALIGN;
               end
            end
            S_ALIGN: begin
               state <= S_READ;
            end
            S_READ: begin
               latch <= bus_din;
               state <= S_WRITE;
            end
            S_WRITE: begin
               idx <= idx + 8'd1;
               if (idx == LAST_IDX) begin
                  rdy        <= 1'b1;
                  dma_active <= 1'b0;
                  state      <= S_IDLE;
               end else begin
                  state <= S_READ;
               end
            end
            default: begin
               rdy        <= 1'b1;
               dma_active <= 1'b0;
               state      <= S_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      bus_addr = cpu_addr;
      bus_dout = cpu_dout;
      bus_rw   = cpu_rw;
      case (state)
         S_ALIGN: bus_rw = RW_READ;
         S_READ: begin
            bus_addr = {page, idx};
            bus_rw   = RW_READ;
         end
         S_WRITE: begin
            bus_addr = OAM_DATA_ADDR;
            bus_dout = latch;
            bus_rw   = RW_WRITE;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Scoreboard bench for oam_dma_ctrl: stimulus queues expected DMA bus cycles, a monitor checks them.
module tb_oam_dma_ctrl;

   typedef struct {
      logic [15:0] addr;
      logic        rw;
      logic [7:0]  data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [15:0] cpu_addr = 16'h0000;
   logic [7:0]  cpu_dout = 8'h00;
   logic        cpu_rw = 1'b1;
   logic [7:0]  bus_din;
   logic        rdy;
   logic [15:0] bus_addr;
   logic [7:0]  bus_dout;
   logic        bus_rw;
   logic        dma_active;

   int   n_assert = 0;
   int   n_fail = 0;
   exp_t exp_q[$];
   logic tb_par;

   oam_dma_ctrl dut (
      .clk_ph1    (clk),
      .rst        (rst_n),
      .cpu_addr   (cpu_addr),
      .cpu_dout   (cpu_dout),
      .cpu_rw     (cpu_rw),
      .bus_din    (bus_din),
      .rdy        (rdy),
      .bus_addr   (bus_addr),
      .bus_dout   (bus_dout),
      .bus_rw     (bus_rw),
      .dma_active (dma_active)
   );

   always #5 clk = ~clk;

   // memory contents: page 2 holds i^$5A; other pages are distinguishable
   function automatic logic [7:0] mem_f(input logic [15:0] a);
      return a[7:0] ^ 8'h5A ^ a[15:8] ^ 8'h02;
   endfunction

   always_comb bus_din = mem_f(bus_addr);

   // get/put phase reference: 0 after reset, toggles every edge
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) tb_par <= 1'b0;
      else        tb_par <= ~tb_par;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && dma_active) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_dma_cycle", {bus_rw, 15'h0, bus_addr}, 32'hFFFF_FFFF);
         end else begin
            e = exp_q.pop_front();
            chk("dma_addr", {16'h0, bus_addr}, {16'h0, e.addr});
            chk("dma_rw", {31'h0, bus_rw}, {31'h0, e.rw});
            if (e.rw == 1'b0) chk("dma_wdata", {24'h0, bus_dout}, {24'h0, e.data});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_par(input logic p);
      for (int i = 0; i < 3 && tb_par != p; i++) tick();
   endtask

   // Trigger a DMA of `page`, with `npend` extra CPU writes (to $4014, must be ignored)
   // during HALT. abort_at>0 asserts reset at that DMA write instead of finishing.
   task automatic do_dma(input logic [7:0] page, input int npend, input int abort_at,
                         output logic align_o);
      exp_t e;
      int   n_edges;
      int   n_wr;
      logic done;
      cpu_addr = 16'h4014; cpu_rw = 1'b0; cpu_dout = page;
      tick();
      n_edges = 0;
      for (int i = 0; i < npend; i++) begin
         cpu_addr = 16'h4014; cpu_rw = 1'b0; cpu_dout = 8'h33;
         @(negedge clk);
         chk("halt_rdy", {31'h0, rdy}, 32'h0);
         chk("halt_passthru_rw", {31'h0, bus_rw}, 32'h0);
         tick();
         n_edges++;
      end
      cpu_addr = 16'h8000; cpu_rw = 1'b1; cpu_dout = 8'h00;
      align_o = ~tb_par;
      if (align_o) begin
         e.addr = 16'h8000; e.rw = 1'b1; e.data = 8'h00;
         exp_q.push_back(e);
      end
      for (int i = 0; i < 256; i++) begin
         e.addr = {page, 8'(i)}; e.rw = 1'b1; e.data = 8'h00;
         exp_q.push_back(e);
         e.addr = 16'h2004; e.rw = 1'b0; e.data = mem_f({page, 8'(i)});
         exp_q.push_back(e);
      end
      @(negedge clk);
      chk("dummy_rdy", {31'h0, rdy}, 32'h0);
      chk("dummy_dma_active", {31'h0, dma_active}, 32'h0);
      n_wr = 0;
      done = 1'b0;
      for (int i = 0; i < 600 && !done; i++) begin
         tick();
         n_edges++;
         if (dma_active && !bus_rw) n_wr++;
         if (abort_at > 0 && n_wr == abort_at) begin
            #1 rst_n = 1'b0;
            #1;
            chk("abort_rdy", {31'h0, rdy}, 32'h1);
            chk("abort_dma_active", {31'h0, dma_active}, 32'h0);
            chk("abort_bus_addr", {16'h0, bus_addr}, 32'h8000);
            chk("abort_bus_rw", {31'h0, bus_rw}, 32'h1);
            exp_q.delete();
            done = 1'b1;
         end else if (rdy) begin
            done = 1'b1;
         end
      end
      if (abort_at == 0) begin
         chk("rdy_latency", n_edges, 32'(npend + 513 + (align_o ? 1 : 0)));
         chk("dma_active_end", {31'h0, dma_active}, 32'h0);
         chk("queue_drained", exp_q.size(), 32'h0);
      end
   endtask

   initial begin
      logic a1, a2, a3;
      #1 rst_n = 1'b0;
      cpu_addr = 16'h0105; cpu_rw = 1'b1;
      #2;
      chk("reset_rdy", {31'h0, rdy}, 32'h1);
      chk("reset_dma_active", {31'h0, dma_active}, 32'h0);
      chk("reset_passthru_addr", {16'h0, bus_addr}, 32'h0105);
      #9 rst_n = 1'b1;

      // idle passthrough
      tick();
      cpu_addr = 16'h0105; cpu_rw = 1'b1;
      @(negedge clk);
      chk("idle_addr", {16'h0, bus_addr}, 32'h0105);
      chk("idle_rw", {31'h0, bus_rw}, 32'h1);
      chk("idle_rdy", {31'h0, rdy}, 32'h1);
      chk("idle_dma_active", {31'h0, dma_active}, 32'h0);
      tick();
      cpu_addr = 16'h0201; cpu_rw = 1'b0; cpu_dout = 8'h07;
      @(negedge clk);
      chk("idle_wr_addr", {16'h0, bus_addr}, 32'h0201);
      chk("idle_wr_data", {24'h0, bus_dout}, 32'h07);
      chk("idle_wr_rw", {31'h0, bus_rw}, 32'h0);
      tick();
      chk("idle_wr_rdy", {31'h0, rdy}, 32'h1);

      // basic DMA in both phase alignments
      wait_par(1'b0);
      do_dma(8'h02, 0, 0, a1);
      wait_par(1'b1);
      do_dma(8'h02, 0, 0, a2);
      chk("both_parities", {31'h0, a1 ^ a2}, 32'h1);

      // pending CPU writes (to $4014 itself) during HALT
      tick();
      do_dma(8'h02, 2, 0, a3);

      // page $FF stays within $FF00-$FFFF
      tick();
      do_dma(8'hFF, 0, 0, a3);

      // non-triggers
      tick();
      cpu_addr = 16'h4015; cpu_rw = 1'b0; cpu_dout = 8'h02;
      tick();
      cpu_addr = 16'h4014; cpu_rw = 1'b1;
      tick();
      cpu_addr = 16'h0000;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("nontrig_rdy", {31'h0, rdy}, 32'h1);
         chk("nontrig_dma_active", {31'h0, dma_active}, 32'h0);
      end

      // reset at the 100th write, then a clean full transfer
      tick();
      do_dma(8'h04, 0, 100, a3);
      #3 rst_n = 1'b1;
      tick();
      cpu_addr = 16'h0300; cpu_rw = 1'b0; cpu_dout = 8'hAA;
      @(negedge clk);
      chk("post_reset_addr", {16'h0, bus_addr}, 32'h0300);
      chk("post_reset_data", {24'h0, bus_dout}, 32'hAA);
      chk("post_reset_rdy", {31'h0, rdy}, 32'h1);
      tick();
      do_dma(8'h05, 0, 0, a3);

      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
